// File: rtl/calc_sequencer.sv
// calc_sequencer -- control FSM for the calculator datapath.
//
// Sequences operand entry, operator selection and execution by pulsing the
// load/select controls of the X register, the Y register (Y <= X) and the ALU.
// Buttons are debounced, clk-synchronous levels; each press is turned into a
// single-cycle edge. No operand data is held here.
//
// Optional feature macro: CALC_CHAIN_EN
//   When defined, an operator press in OPSEL with a second operand already
//   entered executes the pending operation and then chains the new operator
//   (EXEC -> CHAIN -> OPSEL).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   btn_enter  in   level; load X from switches
//   btn_op     in   level; select operator op_code
//   op_code    in   [OPW]   operator sampled on an accepted btn_op edge
//   btn_eq     in   level; execute
//   btn_clr    in   level; clear calculation
//   sw         in   [WIDTH] switch operand
//   x_sw       out  [WIDTH] equals sw (combinational)
//   x_load     out  one-cycle pulse; X register load
//   x_src      out  X mux select: 0 = switches, 1 = ALU result (held)
//   y_load     out  one-cycle pulse; Y <= X
//   alu_op     out  [OPW]   pending operator (registered)
//   regs_clr   out  one-cycle pulse; datapath clear
//   busy       out  1 while in EXEC or CHAIN
//   state_out  out  [3]     IDLE=0 X=1 OPSEL=2 EXEC=3 DONE=4 CHAIN=5
module calc_sequencer #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned OPW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_enter,
  input  logic             btn_op,
  input  logic [OPW-1:0]   op_code,
  input  logic             btn_eq,
  input  logic             btn_clr,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] x_sw,
  output logic             x_load,
  output logic             x_src,
  output logic             y_load,
  output logic [OPW-1:0]   alu_op,
  output logic             regs_clr,
  output logic             busy,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_X     = 3'd1,
    S_OPSEL = 3'd2,
    S_EXEC  = 3'd3,
`ifdef CALC_CHAIN_EN
    S_CHAIN = 3'd5,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_d;

  // Button vector order: {clr, eq, op, enter}
  logic [3:0] btn, btn_q, btn_edge;

  logic           ev_clr, ev_eq, ev_op, ev_enter;
  logic           x_load_d, x_src_d, y_load_d, regs_clr_d, busy_d;
  logic [OPW-1:0] alu_op_d;
  logic           opnd2_valid, opnd2_d;

`ifdef CALC_CHAIN_EN
  logic [OPW-1:0] next_op, next_op_d;
  logic           chain_pend, chain_d;
`endif

  assign x_sw      = sw;
  assign state_out = state;

  assign btn      = {btn_clr, btn_eq, btn_op, btn_enter};
  assign btn_edge = btn & ~btn_q;

  // Only the highest-priority edge of a cycle survives: clr > eq > op > enter.
  assign ev_clr   = btn_edge[3];
  assign ev_eq    = btn_edge[2] & ~btn_edge[3];
  assign ev_op    = btn_edge[1] & ~|btn_edge[3:2];
  assign ev_enter = btn_edge[0] & ~|btn_edge[3:1];

  // Edge-detect flops reset high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_q <= '1;
    else        btn_q <= btn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      x_load      <= 1'b0;
      x_src       <= 1'b0;
      y_load      <= 1'b0;
      alu_op      <= '0;
      regs_clr    <= 1'b0;
      busy        <= 1'b0;
      opnd2_valid <= 1'b0;
`ifdef CALC_CHAIN_EN
      next_op     <= '0;
      chain_pend  <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      x_load      <= x_load_d;
      x_src       <= x_src_d;
      y_load      <= y_load_d;
      alu_op      <= alu_op_d;
      regs_clr    <= regs_clr_d;
      busy        <= busy_d;
      opnd2_valid <= opnd2_d;
`ifdef CALC_CHAIN_EN
      next_op     <= next_op_d;
      chain_pend  <= chain_d;
`endif
    end
  end

  // Outputs are registered from next-state values so that an edge accepted
  // in cycle N shows its pulse in cycle N+1.
  always_comb begin
    state_d    = state;
    x_load_d   = 1'b0;
    x_src_d    = x_src;
    y_load_d   = 1'b0;
    alu_op_d   = alu_op;
    regs_clr_d = 1'b0;
    opnd2_d    = opnd2_valid;
`ifdef CALC_CHAIN_EN
    next_op_d  = next_op;
    chain_d    = chain_pend;
`endif

    if (ev_clr) begin
      regs_clr_d = 1'b1;
      state_d    = S_IDLE;
      opnd2_d    = 1'b0;
      alu_op_d   = '0;
`ifdef CALC_CHAIN_EN
      chain_d    = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ev_enter) begin
            x_load_d = 1'b1;
            x_src_d  = 1'b0;
            state_d  = S_X;
          end
        end

        S_X: begin
          if (ev_op) begin
            y_load_d = 1'b1;
            alu_op_d = op_code;
            opnd2_d  = 1'b0;
            state_d  = S_OPSEL;
          end else if (ev_enter) begin
            x_load_d = 1'b1;
            x_src_d  = 1'b0;
          end
        end

        S_OPSEL: begin
          if (ev_eq) begin
            if (opnd2_valid) begin
              x_load_d = 1'b1;
              x_src_d  = 1'b1;
              state_d  = S_EXEC;
`ifdef CALC_CHAIN_EN
              chain_d  = 1'b0;
`endif
            end
          end else if (ev_op) begin
`ifdef CALC_CHAIN_EN
            if (opnd2_valid) begin
              // Execute with the old operator; the new one waits in next_op.
              next_op_d = op_code;
              chain_d   = 1'b1;
              x_load_d  = 1'b1;
              x_src_d   = 1'b1;
              state_d   = S_EXEC;
            end else begin
              alu_op_d = op_code;
            end
`else
            if (!opnd2_valid) alu_op_d = op_code;
`endif
          end else if (ev_enter) begin
            x_load_d = 1'b1;
            x_src_d  = 1'b0;
            opnd2_d  = 1'b1;
          end
        end

        S_EXEC: begin
`ifdef CALC_CHAIN_EN
          if (chain_pend) begin
            y_load_d = 1'b1;
            alu_op_d = next_op;
            opnd2_d  = 1'b0;
            chain_d  = 1'b0;
            state_d  = S_CHAIN;
          end else begin
            state_d  = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end

`ifdef CALC_CHAIN_EN
        S_CHAIN: begin
          state_d = S_OPSEL;
        end
`endif

        S_DONE: begin
          if (ev_op) begin
            y_load_d = 1'b1;
            alu_op_d = op_code;
            opnd2_d  = 1'b0;
            state_d  = S_OPSEL;
          end else if (ev_enter) begin
            x_load_d = 1'b1;
            x_src_d  = 1'b0;
            state_d  = S_X;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef CALC_CHAIN_EN
  assign busy_d = (state_d == S_EXEC) || (state_d == S_CHAIN);
`else
  assign busy_d = (state_d == S_EXEC);
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned OPW   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             btn_enter = 1'b0, btn_op = 1'b0, btn_eq = 1'b0, btn_clr = 1'b0;
  logic [OPW-1:0]   op_code = '0;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH-1:0] x_sw;
  logic             x_load, x_src, y_load, regs_clr, busy;
  logic [OPW-1:0]   alu_op;
  logic [2:0]       state_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  calc_sequencer #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .btn_enter(btn_enter), .btn_op(btn_op), .op_code(op_code),
    .btn_eq(btn_eq), .btn_clr(btn_clr), .sw(sw),
    .x_sw(x_sw), .x_load(x_load), .x_src(x_src), .y_load(y_load),
    .alu_op(alu_op), .regs_clr(regs_clr), .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven / outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned pulses;

  initial begin
    // Reset with enter held high
    btn_enter = 1'b1;
    repeat (3) tick();
    chk("rst_state", state_out, 0);
    chk("rst_alu", alu_op, 0);
    chk("rst_xload", x_load, 0);
    chk("rst_yload", y_load, 0);
    chk("rst_clr", regs_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xsrc", x_src, 0);
    reset = 1'b1;
    tick(); tick();
    chk("held_no_load", x_load, 0);
    chk("held_state", state_out, 0);
    btn_enter = 1'b0; tick();

    // enter sw=5
    sw = 6'd5; btn_enter = 1'b1; tick();
    chk("ent1_load", x_load, 1);
    chk("ent1_src", x_src, 0);
    chk("ent1_state", state_out, 1);
    chk("x_sw", x_sw, 5);
    btn_enter = 1'b0; tick();
    chk("ent1_pulse_end", x_load, 0);

    // op 2
    op_code = 2'd2; btn_op = 1'b1; tick();
    chk("op2_yload", y_load, 1);
    chk("op2_alu", alu_op, 2);
    chk("op2_state", state_out, 2);
    btn_op = 1'b0; tick();
    chk("op2_pulse_end", y_load, 0);

    // eq with no second operand: ignored
    btn_eq = 1'b1; tick();
    chk("eq_ign_load", x_load, 0);
    chk("eq_ign_state", state_out, 2);
    btn_eq = 1'b0; tick();

    // op replace with opnd2_valid=0
    op_code = 2'd1; btn_op = 1'b1; tick();
    chk("oprep_alu", alu_op, 1);
    chk("oprep_yload", y_load, 0);
    chk("oprep_state", state_out, 2);
    btn_op = 1'b0; tick();

    // enter sw=3
    sw = 6'd3; btn_enter = 1'b1; tick();
    chk("ent2_load", x_load, 1);
    chk("ent2_src", x_src, 0);
    chk("ent2_state", state_out, 2);
    btn_enter = 1'b0; tick();

    // eq -> EXEC -> DONE
    btn_eq = 1'b1; tick();
    chk("exec_load", x_load, 1);
    chk("exec_src", x_src, 1);
    chk("exec_busy", busy, 1);
    chk("exec_state", state_out, 3);
    chk("exec_alu", alu_op, 1);
    tick();
    chk("done_state", state_out, 4);
    chk("done_load", x_load, 0);
    chk("done_busy", busy, 0);
    chk("done_src_hold", x_src, 1);
    btn_eq = 1'b0; tick();

    // eq in DONE ignored
    btn_eq = 1'b1; tick();
    chk("done_eq_load", x_load, 0);
    chk("done_eq_state", state_out, 4);
    btn_eq = 1'b0; tick();

    // op in DONE
    op_code = 2'd3; btn_op = 1'b1; tick();
    chk("done_op_yload", y_load, 1);
    chk("done_op_alu", alu_op, 3);
    chk("done_op_state", state_out, 2);
    btn_op = 1'b0; tick();

    // enter so eq would be valid, then clr+eq together
    sw = 6'd7; btn_enter = 1'b1; tick();
    btn_enter = 1'b0; tick();
    btn_clr = 1'b1; btn_eq = 1'b1; tick();
    chk("clr_pulse", regs_clr, 1);
    chk("clr_no_load", x_load, 0);
    chk("clr_state", state_out, 0);
    chk("clr_alu", alu_op, 0);
    btn_clr = 1'b0; btn_eq = 1'b0; tick();
    chk("clr_pulse_end", regs_clr, 0);

    // IDLE -> X, then hold enter 10 cycles in X
    btn_enter = 1'b1; tick();
    chk("idle_ent_state", state_out, 1);
    btn_enter = 1'b0; tick();
    pulses = 0;
    btn_enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (x_load) pulses++;
    end
    chk("hold_one_pulse", pulses, 1);
    btn_enter = 1'b0; tick();

    // X=4, op 0, X=2, op 3
    sw = 6'd4; btn_enter = 1'b1; tick();
    btn_enter = 1'b0; tick();
    op_code = 2'd0; btn_op = 1'b1; tick();
    chk("ch_op0_alu", alu_op, 0);
    chk("ch_op0_state", state_out, 2);
    btn_op = 1'b0; tick();
    sw = 6'd2; btn_enter = 1'b1; tick();
    btn_enter = 1'b0; tick();
    op_code = 2'd3; btn_op = 1'b1; tick();
`ifdef CALC_CHAIN_EN
    chk("ch_exec_load", x_load, 1);
    chk("ch_exec_src", x_src, 1);
    chk("ch_exec_alu", alu_op, 0);
    chk("ch_exec_state", state_out, 3);
    tick();
    chk("ch_chain_yload", y_load, 1);
    chk("ch_chain_alu", alu_op, 3);
    chk("ch_chain_state", state_out, 5);
    chk("ch_chain_busy", busy, 1);
    tick();
    chk("ch_opsel_state", state_out, 2);
    chk("ch_opsel_yload", y_load, 0);
    chk("ch_opsel_busy", busy, 0);
`else
    chk("noch_load", x_load, 0);
    chk("noch_yload", y_load, 0);
    chk("noch_alu", alu_op, 0);
    chk("noch_state", state_out, 2);
`endif
    btn_op = 1'b0; tick();

    // Reset asserted mid-EXEC
    sw = 6'd1; btn_enter = 1'b1; tick();
    btn_enter = 1'b0; tick();
    btn_eq = 1'b1; tick();
    chk("mid_exec_state", state_out, 3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_state", state_out, 0);
    chk("mid_rst_load", x_load, 0);
    chk("mid_rst_busy", busy, 0);
    btn_eq = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_state", state_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
